// File: rtl/bus_cycle_arbiter.sv
// Two-requester round-robin bus master that runs 8088-style T1/T2/T3/Tw/T4 cycles
// with READY wait states and a bounded wait-state timeout reported through ERR.
module bus_cycle_arbiter #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_WAIT      = 7
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [1:0]                 REQ,
    input  logic [1:0]                 WE,
    input  logic [1:0]                 IOM_IN,
    input  logic [2*ADDRESS_WIDTH-1:0] ADDR_IN,
    input  logic [2*DATA_WIDTH-1:0]    WDATA_IN,
    output logic [1:0]                 ACK,
    output logic                       ERR,
    output logic [DATA_WIDTH-1:0]      RDATA,
    output logic                       ALE,
    output logic                       RD,
    output logic                       WR,
    output logic                       IOM,
    output logic [ADDRESS_WIDTH-1:0]   ADDR,
    output logic [DATA_WIDTH-1:0]      DATA_OUT,
    output logic                       DATA_OE,
    input  logic [DATA_WIDTH-1:0]      DATA_IN,
    input  logic                       READY
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TW   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_last;
    logic                     r_grant;
    logic                     r_we;
    logic                     r_iom;
    logic                     r_timeout;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [CW-1:0]            r_wait;

    logic                     w_any;
    logic                     w_sel;
    logic                     w_wait_max;
    logic                     w_ale;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_oe;
    logic [1:0]               w_ack;
    logic                     w_err;

    // The requester not granted last wins on contention; a lone requester wins outright.
    assign w_any      = |REQ;
    assign w_sel      = (REQ == 2'b11) ? ~r_last : REQ[1];
    assign w_wait_max = (r_wait == CW'(MAX_WAIT));

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_T1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_T1: w_next = S_T2;
            S_T2: w_next = S_T3;
            S_T3: begin
                if (READY) begin
                    w_next = S_T4;
                end else begin
                    w_next = S_TW;
                end
            end
            S_TW: begin
                if (READY || w_wait_max) begin
                    w_next = S_T4;
                end else begin
                    w_next = S_TW;
                end
            end
            S_T4:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer context, wait counter, read data and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last    <= 1'b1;
            r_grant   <= 1'b0;
            r_we      <= 1'b0;
            r_iom     <= 1'b0;
            r_timeout <= 1'b0;
            r_addr    <= {ADDRESS_WIDTH{1'b0}};
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_wait    <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_sel;
                        r_we      <= WE[w_sel];
                        r_iom     <= IOM_IN[w_sel];
                        r_addr    <= w_sel ? ADDR_IN[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                           : ADDR_IN[ADDRESS_WIDTH-1:0];
                        r_wdata   <= w_sel ? WDATA_IN[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : WDATA_IN[DATA_WIDTH-1:0];
                        r_timeout <= 1'b0;
                    end
                end
                S_T3: begin
                    if (READY) begin
                        if (!r_we) begin
                            r_rdata <= DATA_IN;
                        end
                    end else begin
                        r_wait <= CW'(1);
                    end
                end
                S_TW: begin
                    if (READY) begin
                        if (!r_we) begin
                            r_rdata <= DATA_IN;
                        end
                    end else if (w_wait_max) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_T4: begin
                    r_last <= r_grant;
                end
                default: begin
                    r_last <= r_last;
                end
            endcase
        end
    end

    // Bus strobes and handshake decoded purely from the registered state.
    always_comb begin
        w_ale = 1'b0;
        w_rd  = 1'b1;
        w_wr  = 1'b1;
        w_oe  = 1'b0;
        w_ack = 2'b00;
        w_err = 1'b0;
        case (r_state)
            S_T1: w_ale = 1'b1;
            S_T2, S_T3, S_TW: begin
                if (r_we) begin
                    w_wr = 1'b0;
                    w_oe = 1'b1;
                end else begin
                    w_rd = 1'b0;
                end
            end
            S_T4: begin
                w_oe  = r_we;
                w_ack = r_grant ? 2'b10 : 2'b01;
                w_err = r_timeout;
            end
            default: w_ale = 1'b0;
        endcase
    end

    assign ALE      = w_ale;
    assign RD       = w_rd;
    assign WR       = w_wr;
    assign DATA_OE  = w_oe;
    assign ACK      = w_ack;
    assign ERR      = w_err;
    assign IOM      = r_iom;
    assign ADDR     = r_addr;
    assign DATA_OUT = r_wdata;
    assign RDATA    = r_rdata;

endmodule

// File: doc/bus_cycle_arbiter.md
# bus_cycle_arbiter

Two-requester bus master that shares the 8088-style peripheral bus and sequences every transfer as a T1/T2/T3/(Tw)/T4 cycle. It drives ALE, RD, WR, IOM and the address that the memory and IO peripheral modules decode. It handles READY wait states and a wait-state timeout. It sits between internal requesters (CPU model, DMA engine) and the peripheral bus.

## Interface
- ADDRESS_WIDTH, default 20: bus address width.
- DATA_WIDTH, default 8: bus data width.
- MAX_WAIT, default 7: maximum Tw states before the cycle is aborted with ERR.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester transfer request; held high until that requester's ACK.
- WE  in  2  per-requester: 1 = write, 0 = read.
- IOM_IN  in  2  per-requester IO/memory select; copied to IOM.
- ADDR_IN  in  2*ADDRESS_WIDTH  requester n address at bits [n*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- WDATA_IN  in  2*DATA_WIDTH  requester n write data at bits [n*DATA_WIDTH +: DATA_WIDTH].
- ACK  out  2  one-cycle completion pulse to the granted requester.
- ERR  out  1  one-cycle pulse coincident with ACK when the cycle timed out.
- RDATA  out  DATA_WIDTH  read data; valid from the ACK cycle until the next read completes.
- ALE  out  1  address latch enable, high in T1 only.
- RD  out  1  active-low read strobe.
- WR  out  1  active-low write strobe.
- IOM  out  1  bus IO/memory qualifier.
- ADDR  out  ADDRESS_WIDTH  bus address.
- DATA_OUT  out  DATA_WIDTH  write data to the bus.
- DATA_OE  out  1  enables DATA_OUT onto the shared bus.
- DATA_IN  in  DATA_WIDTH  bus read data.
- READY  in  1  peripheral ready; low inserts wait states.

## Operation
- FSM states: IDLE, T1, T2, T3, TW, T4.
- **IDLE:** if any REQ bit is high, pick a requester by round-robin: the requester not granted last wins on contention, and a lone requester wins immediately. Latch its ADDR/WE/IOM/WDATA into internal registers, then go to T1. With no request, stay in IDLE.
- **T1:** ALE=1. ADDR and IOM are driven from the latched values and held through T4. Next state is T2.
- **T2:** read drives RD=0; write drives WR=0 and DATA_OE=1. Next state is T3.
- **T3:** the strobe is held.
  - READY=1: go to T4. For a read, capture DATA_IN into RDATA on this edge.
  - READY=0: go to TW and clear the wait counter to 1.
- **TW:** the strobe is held.
  - READY=1: go to T4 and capture read data.
  - READY=0 with wait count == MAX_WAIT: go to T4 with the timeout flag set; RDATA is not updated.
  - Otherwise: increment the counter and stay in TW.
- **T4:** RD=WR=1 and ALE=0. ACK[granted]=1, ERR=timeout flag. DATA_OE stays 1 for writes in T4. Update the round-robin pointer, then go to IDLE.
- Wait counter width is clog2(MAX_WAIT+1). It never wraps.
- A requester dropping REQ mid-cycle does not abort the cycle; ACK is still issued.
- REQ changes on the non-granted line during a cycle are ignored until IDLE.

## Timing
- Reset values, forced on the first rising edge with RESET=1:
  - State IDLE; ALE=0, RD=1, WR=1, IOM=0, ADDR=0, DATA_OUT=0, DATA_OE=0, ACK=0, ERR=0, RDATA=0.
  - Round-robin pointer is set so requester 0 wins first contention.
- RESET asserted mid-cycle aborts the transfer. Strobes deassert on that edge and no ACK is issued. The requester must re-request.
- All bus outputs are registered or decoded only from registered state; no combinational path exists from REQ or READY to bus outputs.
- Latency: with REQ sampled high in IDLE at cycle 0, T1=1, T2=2, T3=3, and ACK is in cycle 4. Each Tw adds one cycle.
- Throughput: one IDLE cycle separates consecutive transfers, giving 5 cycles per zero-wait transfer.
- Timeout cycle: ACK and ERR arrive at cycle 4+MAX_WAIT.

## Test plan
- **Single read:** REQ=2'b01, WE=0, IOM_IN=0, ADDR_IN[19:0]=20'h0_1234, READY=1, DATA_IN=8'hA5.
  - ALE high in cycle 1 and RD low in cycles 2-3.
  - ACK=2'b01 in cycle 4 with RDATA=8'hA5 and ERR=0.
- **Single write:** requester 1, WE=1, IOM_IN=1, addr 20'h0_0080, WDATA 8'h3C.
  - WR low in cycles 2-3, DATA_OE high in cycles 2-4, DATA_OUT=8'h3C, IOM=1.
  - ACK=2'b10 in cycle 4.
- **Contention:** REQ=2'b11 held continuously for four transfers.
  - Grants alternate 0,1,0,1 and ACKs are 5 cycles apart.
- **Wait states:** READY low for 3 cycles from T3.
  - Three TW cycles occur and the strobe is held.
  - ACK arrives in cycle 7 with correct RDATA.
- **Timeout:** READY stuck low with MAX_WAIT=7.
  - ACK and ERR are both high in cycle 11, RDATA is unchanged, and RD returns high.
- **Reset mid-cycle:** RESET asserted during TW.
  - Next cycle shows all outputs at their reset values and no ACK.
  - A fresh REQ afterwards completes normally.
